lfsr_stream_cipher_engine: RTL and testbench
============================================

Name: lfsr_stream_cipher_engine

Overview:
- Parametrised, word-wide successor to the bit-serial keyed LFSR cipher. Seeds a Fibonacci LFSR from a key, optionally discards a warm-up run, then XORs each DATA_W-bit input word with the next DATA_W keystream bits.
- Encryption and decryption are the same operation. Valid/ready streams on both sides, with a single registered output stage.
- Sits between a byte/word source and a link or storage sink.

Parameters:
- LFSR_W, 8, LFSR register width (>=4).
- DATA_W, 8, data word width; keystream bits consumed per word (1..LFSR_W).
- TAPS, 8'h1D, feedback mask, LFSR_W bits; bit 0 must be set.
- WARMUP_STEPS, 0, LFSR steps discarded after key load before data is accepted.
- SEED_FALLBACK, 1, seed used when key == 0; nonzero.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- key  in  LFSR_W  seed value.
- key_load  in  1  single-cycle pulse; (re)seeds from key.
- in_data  in  DATA_W  plaintext or ciphertext word.
- in_valid  in  1  input word valid.
- in_ready  out  1  engine accepts a word this cycle.
- out_data  out  DATA_W  in_data XOR keystream word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts out_data.
- keyed  out  1  engine is in RUN.
- lfsr_state  out  LFSR_W  current LFSR register (debug).

Behaviour:
- Reset (rst low, asynchronous): FSM=IDLE, lfsr_state=0, out_data=0, out_valid=0, keyed=0, warm-up counter=0.
- LFSR step:
  - Output bit = state[0].
  - fb = XOR-reduce(state & TAPS).
  - next = {fb, state[LFSR_W-1:1]}.
- Keystream word: DATA_W consecutive steps, unrolled combinationally in one cycle. Bit i of the word is the output of step i (LSB first). After the word, the state has advanced DATA_W steps.
- FSM states:
  - IDLE: in_ready=0. key_load -> seed, then WARMUP (if WARMUP_STEPS>0) or RUN.
  - WARMUP: one LFSR step per cycle, counter 0..WARMUP_STEPS-1. After the last step -> RUN. in_ready=0.
  - RUN: keyed=1. in_ready = !out_valid || out_ready.
- Seed: state <= (key==0) ? SEED_FALLBACK : key. The register never holds 0 outside reset.
- Transfer (in_valid && in_ready in RUN):
  - out_data <= in_data ^ ks_word; out_valid <= 1 on the next edge.
  - LFSR advances DATA_W steps on the same edge.
  - Latency is 1 cycle.
- Output: out_valid && out_ready with no new transfer -> out_valid <= 0. Simultaneous pop and push keeps out_valid=1 with the new word (full throughput, 1 word/cycle).
- Backpressure: while out_valid && !out_ready, out_data is held stable, in_ready=0, and the LFSR does not advance.
- key_load in any state (including mid-stream or mid-warm-up):
  - Reseeds and restarts the warm-up counter.
  - Clears out_valid; the pending word is dropped.
  - Takes priority over a simultaneous transfer, which is not accepted: in_ready is forced to 0 in the key_load cycle.
- Reset asserted mid-operation returns everything to reset values immediately.

Decomposition:
- Shared package lfsr_cipher_pkg:
  - FSM state enum (IDLE, WARMUP, RUN).
  - Default TAPS constants per width (8:'h1D, 16:'h002D, 32:'h00000057 in this right-shift form).
  - Function lfsr_step(state, taps).
- Sub-module lfsr_keystream_gen: combinational, state -> {ks_word, next_state} over DATA_W unrolled steps. It is reused by the receive-side instance.
- The engine top holds the FSM, counter, LFSR register and output stage.

Test Plan:
- Basic encrypt: defaults, key=8'h01, key_load; send 8'hAB then 8'h00 with out_ready=1. Expect out_data=8'hAA then 8'h71, with lfsr_state 8'h71 then 8'hA4.
- Round trip: instance A encrypts 16 random words under key 8'hC3; instance B (same key) decrypts A's output. B out_data equals the original sequence exactly.
- Zero key: key=0, key_load. Expect lfsr_state=SEED_FALLBACK (8'h01) and the same outputs as the key=8'h01 case.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1. out_data and lfsr_state stay stable and in_ready=0. Release it; the sequence is identical to the no-stall case.
- Warm-up: WARMUP_STEPS=8, key=8'h01. in_ready stays 0 for 8 cycles after key_load; the first word's keystream is 8'h71 (8'hAB -> 8'hDA).
- Mid-stream rekey and reset:
  - key_load mid-stream with out_valid=1 -> out_valid=0 next cycle, and the stream restarts from the new seed.
  - rst low asynchronously between edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/lfsr_cipher_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_cipher_pkg
// Shared definitions for the LFSR stream cipher: FSM state encoding, default
// right-shift Fibonacci tap masks per register width, and the single-step
// LFSR helper used by both the keystream generator and the engine warm-up.
// ---------------------------------------------------------------------------
package lfsr_cipher_pkg;

    // Widest LFSR the helper functions can carry; callers zero-extend into it.
    localparam int LFSR_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        RUN
    } cipher_state_e;

    // Tap masks for the right-shift form: bit 0 is always part of the feedback.
    localparam logic [7:0]  TAPS_W8  = 8'h1D;
    localparam logic [15:0] TAPS_W16 = 16'h002D;
    localparam logic [31:0] TAPS_W32 = 32'h00000057;

    function automatic logic [LFSR_MAX_W-1:0] default_taps(input int w);
        case (w)
            16:      return LFSR_MAX_W'(TAPS_W16);
            32:      return LFSR_MAX_W'(TAPS_W32);
            default: return LFSR_MAX_W'(TAPS_W8);
        endcase
    endfunction

    // One Fibonacci step of a w-bit register held in the low bits of `state`
    // (upper bits must be zero). Feedback enters at the MSB, output is bit 0.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps,
        input int                    w
    );
        logic fb;
        fb = ^(state & taps);
        return (state >> 1) | (LFSR_MAX_W'(fb) << (w - 1));
    endfunction

endpackage

// File: rtl/lfsr_keystream_gen.sv
// ---------------------------------------------------------------------------
// lfsr_keystream_gen
// Purely combinational: unrolls DATA_W LFSR steps from state_in. Bit i of
// ks_word is the output bit (state[0]) of step i, LSB first; state_out is the
// register value after all DATA_W steps.
//
// Ports:
//   state_in  [LFSR_W-1:0]  current LFSR register
//   ks_word   [DATA_W-1:0]  keystream word for this transfer
//   state_out [LFSR_W-1:0]  register after DATA_W steps
// ---------------------------------------------------------------------------
module lfsr_keystream_gen
    import lfsr_cipher_pkg::*;
#(
    parameter int                LFSR_W = 8,
    parameter int                DATA_W = 8,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(default_taps(LFSR_W))
) (
    input  logic [LFSR_W-1:0] state_in,
    output logic [DATA_W-1:0] ks_word,
    output logic [LFSR_W-1:0] state_out
);

    logic [LFSR_W-1:0] walk;

    always_comb begin
        ks_word = '0;
        walk    = state_in;
        for (int i = 0; i < DATA_W; i++) begin
            ks_word[i] = walk[0];
            walk = LFSR_W'(lfsr_step(LFSR_MAX_W'(walk), LFSR_MAX_W'(TAPS), LFSR_W));
        end
        state_out = walk;
    end

endmodule

// File: rtl/lfsr_stream_cipher_engine.sv
// ---------------------------------------------------------------------------
// lfsr_stream_cipher_engine
// Keyed Fibonacci-LFSR stream cipher. A key_load pulse seeds the register
// (a zero key is replaced by SEED_FALLBACK so the LFSR never locks up), an
// optional warm-up run discards WARMUP_STEPS steps, then each accepted input
// word is XORed with the next DATA_W keystream bits. Encrypt == decrypt.
// One registered output stage gives 1-cycle latency at 1 word/cycle.
//
// Ports:
//   clk, rst (async, active-low)
//   key [LFSR_W-1:0], key_load     seed value and (re)seed pulse
//   in_data/in_valid/in_ready      input word stream
//   out_data/out_valid/out_ready   output word stream (registered)
//   keyed                          engine is in RUN
//   lfsr_state [LFSR_W-1:0]        current LFSR register (debug)
// ---------------------------------------------------------------------------
module lfsr_stream_cipher_engine
    import lfsr_cipher_pkg::*;
#(
    parameter int                LFSR_W        = 8,
    parameter int                DATA_W        = 8,
    parameter logic [LFSR_W-1:0] TAPS          = LFSR_W'(default_taps(LFSR_W)),
    parameter int                WARMUP_STEPS  = 0,
    parameter logic [LFSR_W-1:0] SEED_FALLBACK = LFSR_W'(1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LFSR_W-1:0] key,
    input  logic              key_load,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              keyed,
    output logic [LFSR_W-1:0] lfsr_state
);

    localparam int CNT_W = (WARMUP_STEPS > 1) ? $clog2(WARMUP_STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((WARMUP_STEPS > 0) ? (WARMUP_STEPS - 1) : 0);

    cipher_state_e     state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    logic [DATA_W-1:0] ks_word;
    logic [LFSR_W-1:0] lfsr_after_word;
    logic              xfer;

    lfsr_keystream_gen #(
        .LFSR_W (LFSR_W),
        .DATA_W (DATA_W),
        .TAPS   (TAPS)
    ) u_ks (
        .state_in  (lfsr_q),
        .ks_word   (ks_word),
        .state_out (lfsr_after_word)
    );

    // key_load wins over a same-cycle transfer, so it masks in_ready.
    assign in_ready   = (state_q == RUN) && (!out_valid_q || out_ready) && !key_load;
    assign xfer       = in_valid && in_ready;
    assign keyed      = (state_q == RUN);
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign lfsr_state = lfsr_q;

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (key_load) begin
            lfsr_d      = (key == '0) ? SEED_FALLBACK : key;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            state_d     = (WARMUP_STEPS > 0) ? WARMUP : RUN;
        end else begin
            case (state_q)
                IDLE: begin
                end
                WARMUP: begin
                    lfsr_d = LFSR_W'(lfsr_step(LFSR_MAX_W'(lfsr_q), LFSR_MAX_W'(TAPS), LFSR_W));
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    // A push covers a simultaneous pop; otherwise a pop empties the stage.
                    if (xfer) begin
                        out_data_d  = in_data ^ ks_word;
                        out_valid_d = 1'b1;
                        lfsr_d      = lfsr_after_word;
                    end else if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            lfsr_q      <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_lfsr_stream_cipher_engine.sv
// ---------------------------------------------------------------------------
// tb_lfsr_stream_cipher_engine
// Instances: A (defaults), B (defaults, decrypts A's output in the round-trip
// scenario), W (WARMUP_STEPS = 8). Expected values come from a word-level
// reference model of the cipher kept in this file.
// ---------------------------------------------------------------------------
module tb_lfsr_stream_cipher_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   total = 0;
    int   bad   = 0;
    bit   chain = 1'b0;

    // Instance A
    logic [7:0] a_key, a_in_data, a_out_data, a_lfsr;
    logic       a_key_load, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_keyed;
    logic       tb_a_out_ready;
    // Instance B
    logic [7:0] b_key, b_in_data, b_out_data, b_lfsr;
    logic       b_key_load, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_keyed;
    // Instance W
    logic [7:0] w_key, w_in_data, w_out_data, w_lfsr;
    logic       w_key_load, w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_keyed;

    assign a_out_ready = chain ? b_in_ready : tb_a_out_ready;
    assign b_in_data   = a_out_data;
    assign b_in_valid  = chain & a_out_valid;
    assign b_out_ready = 1'b1;

    lfsr_stream_cipher_engine dut_a (
        .clk(clk), .rst(rst), .key(a_key), .key_load(a_key_load),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .keyed(a_keyed), .lfsr_state(a_lfsr)
    );

    lfsr_stream_cipher_engine dut_b (
        .clk(clk), .rst(rst), .key(b_key), .key_load(b_key_load),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .keyed(b_keyed), .lfsr_state(b_lfsr)
    );

    lfsr_stream_cipher_engine #(.WARMUP_STEPS(8)) dut_w (
        .clk(clk), .rst(rst), .key(w_key), .key_load(w_key_load),
        .in_data(w_in_data), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .out_data(w_out_data), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .keyed(w_keyed), .lfsr_state(w_lfsr)
    );

    // ---------------- reference model (instance A, no warm-up) ----------------
    logic [7:0] m_st, m_od;
    bit         m_ov, m_keyed;

    function automatic logic [7:0] step8(input logic [7:0] s);
        int ones;
        ones = $countones(s & 8'h1D);
        return {ones[0], s[7:1]};
    endfunction

    // Returns {state after 8 steps, keystream byte}
    function automatic logic [15:0] ks_and_next(input logic [7:0] s);
        logic [7:0] ks;
        logic [7:0] st;
        st = s;
        ks = 8'h00;
        for (int i = 0; i < 8; i++) begin
            ks[i] = st[0];
            st    = step8(st);
        end
        return {st, ks};
    endfunction

    task automatic model_reset();
        m_st = 8'h00; m_od = 8'h00; m_ov = 1'b0; m_keyed = 1'b0;
    endtask

    task automatic model_edge(input bit kl, input logic [7:0] k, input bit iv,
                              input logic [7:0] d, input bit ordy);
        logic [15:0] r;
        bit          rdy;
        rdy = m_keyed && (!m_ov || ordy) && !kl;
        if (kl) begin
            m_st = (k == 8'h00) ? 8'h01 : k;
            m_ov = 1'b0;
            m_keyed = 1'b1;
        end else if (iv && rdy) begin
            r    = ks_and_next(m_st);
            m_od = d ^ r[7:0];
            m_st = r[15:8];
            m_ov = 1'b1;
        end else if (m_ov && ordy) begin
            m_ov = 1'b0;
        end
    endtask

    // ---------------- common sequencing ----------------
    task automatic do_reset();
        a_key = 0; a_key_load = 0; a_in_data = 0; a_in_valid = 0; tb_a_out_ready = 0;
        b_key = 0; b_key_load = 0;
        w_key = 0; w_key_load = 0; w_in_data = 0; w_in_valid = 0; w_out_ready = 0;
        chain = 1'b0;
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [7:0] k);
        a_key = k; a_key_load = 1'b1; a_in_valid = 1'b0;
        @(posedge clk);
        #1 a_key_load = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        a_key = 0; a_key_load = 0; a_in_data = 0; a_in_valid = 0; tb_a_out_ready = 1;
        b_key = 0; b_key_load = 0;
        w_key = 0; w_key_load = 0; w_in_data = 0; w_in_valid = 0; w_out_ready = 0;
        #3 rst = 1'b0;
        #2;
        total++; if (a_out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data: got %h want 00", a_out_data); end
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
        total++; if (a_keyed !== 1'b0) begin bad++; $display("FAIL reset_keyed: got %b want 0", a_keyed); end
        total++; if (a_lfsr !== 8'h00) begin bad++; $display("FAIL reset_lfsr: got %h want 00", a_lfsr); end
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", a_in_ready); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++; if (a_keyed !== 1'b0 || a_in_ready !== 1'b0) begin bad++; $display("FAIL idle_after_reset: keyed=%b in_ready=%b want 0 0", a_keyed, a_in_ready); end
    endtask

    task automatic test_basic(input logic [7:0] k, input string nm);
        do_reset();
        load_a(k);
        total++; if (a_lfsr !== 8'h01) begin bad++; $display("FAIL %s_seed: got %h want 01", nm, a_lfsr); end
        total++; if (a_keyed !== 1'b1) begin bad++; $display("FAIL %s_keyed: got %b want 1", nm, a_keyed); end
        a_in_data = 8'hAB; a_in_valid = 1'b1; tb_a_out_ready = 1'b1;
        #1;
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL %s_in_ready: got %b want 1", nm, a_in_ready); end
        @(posedge clk); #1;
        total++; if (a_out_data !== 8'hAA || a_out_valid !== 1'b1) begin bad++; $display("FAIL %s_word0: got %h/%b want AA/1", nm, a_out_data, a_out_valid); end
        total++; if (a_lfsr !== 8'h71) begin bad++; $display("FAIL %s_lfsr0: got %h want 71", nm, a_lfsr); end
        a_in_data = 8'h00;
        @(posedge clk); #1;
        total++; if (a_out_data !== 8'h71 || a_out_valid !== 1'b1) begin bad++; $display("FAIL %s_word1: got %h/%b want 71/1", nm, a_out_data, a_out_valid); end
        total++; if (a_lfsr !== 8'hA4) begin bad++; $display("FAIL %s_lfsr1: got %h want A4", nm, a_lfsr); end
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL %s_drain: out_valid got %b want 0", nm, a_out_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        load_a(8'h01);
        a_in_data = 8'hAB; a_in_valid = 1'b1; tb_a_out_ready = 1'b0;
        @(posedge clk); #1;
        a_in_data = 8'h00;
        for (int i = 0; i < 5; i++) begin
            total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, a_in_ready); end
            total++; if (a_out_data !== 8'hAA || a_out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold[%0d]: got %h/%b want AA/1", i, a_out_data, a_out_valid); end
            total++; if (a_lfsr !== 8'h71) begin bad++; $display("FAIL bp_lfsr[%0d]: got %h want 71", i, a_lfsr); end
            @(posedge clk); #1;
        end
        tb_a_out_ready = 1'b1;
        #1;
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", a_in_ready); end
        @(posedge clk); #1;
        total++; if (a_out_data !== 8'h71 || a_lfsr !== 8'hA4) begin bad++; $display("FAIL bp_after: got %h/%h want 71/A4", a_out_data, a_lfsr); end
        a_in_valid = 1'b0;
    endtask

    task automatic test_random_stream();
        bit         kl, iv, ordy, exp_rdy;
        logic [7:0] k, d;
        do_reset();
        for (int i = 0; i < 120; i++) begin
            kl   = (i == 0) || ($urandom_range(0, 24) == 0);
            k    = (i == 0) ? 8'h5C : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) k = 8'h00;
            iv   = ($urandom_range(0, 3) != 0);
            d    = 8'($urandom_range(0, 255));
            ordy = ($urandom_range(0, 2) != 0);
            a_key = k; a_key_load = kl; a_in_valid = iv; a_in_data = d; tb_a_out_ready = ordy;
            exp_rdy = m_keyed && (!m_ov || ordy) && !kl;
            #1;
            total++; if (a_in_ready !== exp_rdy) begin bad++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", i, a_in_ready, exp_rdy); end
            @(posedge clk);
            model_edge(kl, k, iv, d, ordy);
            #1;
            total++; if (a_out_valid !== m_ov) begin bad++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", i, a_out_valid, m_ov); end
            total++; if (a_lfsr !== m_st) begin bad++; $display("FAIL rnd_lfsr[%0d]: got %h want %h", i, a_lfsr, m_st); end
            if (m_ov) begin
                total++; if (a_out_data !== m_od) begin bad++; $display("FAIL rnd_out_data[%0d]: got %h want %h", i, a_out_data, m_od); end
            end
        end
        a_key_load = 1'b0; a_in_valid = 1'b0;
    endtask

    task automatic test_rekey();
        logic [15:0] r;
        do_reset();
        load_a(8'h01);
        a_in_data = 8'hAB; a_in_valid = 1'b1; tb_a_out_ready = 1'b0;
        @(posedge clk); #1;
        a_key = 8'h5A; a_key_load = 1'b1; a_in_data = 8'h00;
        #1;
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL rekey_in_ready: got %b want 0", a_in_ready); end
        tb_a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_key_load = 1'b0;
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rekey_drop: out_valid got %b want 0", a_out_valid); end
        total++; if (a_lfsr !== 8'h5A) begin bad++; $display("FAIL rekey_seed: got %h want 5A", a_lfsr); end
        r = ks_and_next(8'h5A);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        total++; if (a_out_data !== r[7:0] || a_out_valid !== 1'b1) begin bad++; $display("FAIL rekey_word: got %h/%b want %h/1", a_out_data, a_out_valid, r[7:0]); end
        total++; if (a_lfsr !== r[15:8]) begin bad++; $display("FAIL rekey_lfsr: got %h want %h", a_lfsr, r[15:8]); end
    endtask

    task automatic test_warmup();
        do_reset();
        w_key = 8'h01; w_key_load = 1'b1;
        @(posedge clk); #1;
        w_key_load = 1'b0;
        w_in_data = 8'hAB; w_in_valid = 1'b1; w_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++; if (w_in_ready !== 1'b0) begin bad++; $display("FAIL warm_in_ready[%0d]: got %b want 0", i, w_in_ready); end
            @(posedge clk); #1;
        end
        total++; if (w_in_ready !== 1'b1 || w_keyed !== 1'b1) begin bad++; $display("FAIL warm_run: in_ready=%b keyed=%b want 1 1", w_in_ready, w_keyed); end
        total++; if (w_lfsr !== 8'h71) begin bad++; $display("FAIL warm_lfsr: got %h want 71", w_lfsr); end
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        total++; if (w_out_data !== 8'hDA || w_out_valid !== 1'b1) begin bad++; $display("FAIL warm_word: got %h/%b want DA/1", w_out_data, w_out_valid); end
    endtask

    task automatic test_round_trip();
        logic [7:0] words[16];
        logic [7:0] got[$];
        int         sent;
        bit         acc;
        do_reset();
        for (int i = 0; i < 16; i++) words[i] = 8'($urandom_range(0, 255));
        chain = 1'b1;
        a_key = 8'hC3; b_key = 8'hC3; a_key_load = 1'b1; b_key_load = 1'b1;
        @(posedge clk); #1;
        a_key_load = 1'b0; b_key_load = 1'b0;
        sent = 0;
        for (int cyc = 0; cyc < 400 && got.size() < 16; cyc++) begin
            a_in_valid = (sent < 16) && ($urandom_range(0, 3) != 0);
            a_in_data  = (sent < 16) ? words[sent] : 8'h00;
            #1;
            acc = a_in_valid && a_in_ready;
            @(posedge clk);
            if (acc) sent++;
            #1;
            if (b_out_valid) got.push_back(b_out_data);
        end
        a_in_valid = 1'b0;
        total++; if (got.size() != 16) begin bad++; $display("FAIL rt_count: got %0d words want 16", got.size()); end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            total++; if (got[i] !== words[i]) begin bad++; $display("FAIL rt_word[%0d]: got %h want %h", i, got[i], words[i]); end
        end
        chain = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        load_a(8'h01);
        a_in_data = 8'hAB; a_in_valid = 1'b1; tb_a_out_ready = 1'b0;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        total++; if (a_out_data !== 8'h00 || a_out_valid !== 1'b0) begin bad++; $display("FAIL arst_out: got %h/%b want 00/0", a_out_data, a_out_valid); end
        total++; if (a_keyed !== 1'b0 || a_lfsr !== 8'h00) begin bad++; $display("FAIL arst_state: keyed=%b lfsr=%h want 0/00", a_keyed, a_lfsr); end
        #2 rst = 1'b1;
        @(posedge clk); #1;
        total++; if (a_keyed !== 1'b0 || a_in_ready !== 1'b0) begin bad++; $display("FAIL arst_idle: keyed=%b in_ready=%b want 0 0", a_keyed, a_in_ready); end
    endtask

    initial begin
        test_reset();
        test_basic(8'h01, "basic");
        test_basic(8'h00, "zerokey");
        test_backpressure();
        test_random_stream();
        test_rekey();
        test_warmup();
        test_round_trip();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
